// File: rtl/blit_rect_copy.sv
// Rectangle copy engine: raster-order reads from a 1-cycle-latency sprite memory,
// then transparency keying and writes through a stallable pixel-buffer port.
module blit_rect_copy #(
  parameter int ADDR_W = 16,
  parameter int PIX_W  = 8,
  parameter int DIM_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_src,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [DIM_W-1:0]  cmd_w,
  input  logic [DIM_W-1:0]  cmd_h,
  input  logic [ADDR_W-1:0] cmd_src_stride,
  input  logic [ADDR_W-1:0] cmd_dst_stride,
  input  logic              cmd_key_en,
  input  logic [PIX_W-1:0]  cmd_key,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [PIX_W-1:0]  rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PIX_W-1:0]  wr_data,
  input  logic              wr_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t state, next_state;

  // Latched command fields; row bases advance by stride at each row end.
  logic [ADDR_W-1:0] src_row, dst_row;
  logic [ADDR_W-1:0] src_stride_q, dst_stride_q;
  logic [DIM_W-1:0]  x_cnt, y_cnt;
  logic [DIM_W-1:0]  w_last, h_last;
  logic              key_en_q;
  logic [PIX_W-1:0]  key_q;
  logic              rd_pending;

  // Read in flight, carrying its destination tag until rd_data returns.
  logic              s1_valid;
  logic [ADDR_W-1:0] s1_tag;

  // Two-entry capture FIFO.
  logic [PIX_W-1:0]  fifo_data [2];
  logic [ADDR_W-1:0] fifo_addr [2];
  logic              head_ptr, tail_ptr;
  logic [1:0]        occ;

  logic              done_q;

  logic              accept;
  logic              zero_size;
  logic              head_valid;
  logic              head_transparent;
  logic              pop;
  logic [2:0]        fill_next;
  logic              credit_ok;
  logic              last_col;
  logic              last_row;
  logic              finish;

  assign accept           = cmd_valid && (state == IDLE);
  assign zero_size        = (cmd_w == '0) || (cmd_h == '0);
  assign head_valid       = (occ != 2'd0);
  assign head_transparent = head_valid && key_en_q && (fifo_data[head_ptr] == key_q);
  assign pop              = head_valid && (head_transparent || wr_ready);

  // Entries held next cycle before counting a new read; a read is allowed only
  // if its data will still find a free slot, so the FIFO can never overflow.
  assign fill_next = {1'b0, occ} + {2'b0, s1_valid} - {2'b0, pop};
  assign credit_ok = (fill_next < 3'd2);

  assign last_col = (x_cnt == w_last);
  assign last_row = (y_cnt == h_last);
  assign finish   = (state == RUN) && !rd_pending && !s1_valid && (fill_next == 3'd0);

  assign rd_addr = src_row + ADDR_W'(x_cnt);
  assign wr_addr = fifo_addr[head_ptr];
  assign wr_data = fifo_data[head_ptr];
  assign done    = done_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples pre-edge values regardless of block evaluation order.
      state <= next_state;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    next_state = state;
    cmd_ready  = 1'b0;
    busy       = 1'b0;
    rd_en      = 1'b0;
    wr_en      = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (accept && !zero_size) begin
          next_state = RUN;
        end
      end
      RUN: begin
        busy  = 1'b1;
        rd_en = rd_pending && credit_ok;
        // Depends only on FIFO state, never on wr_ready.
        wr_en = head_valid && !head_transparent;
        if (finish) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      src_row      <= '0;
      dst_row      <= '0;
      src_stride_q <= '0;
      dst_stride_q <= '0;
      x_cnt        <= '0;
      y_cnt        <= '0;
      w_last       <= '0;
      h_last       <= '0;
      key_en_q     <= 1'b0;
      key_q        <= '0;
      rd_pending   <= 1'b0;
      s1_valid     <= 1'b0;
      s1_tag       <= '0;
      done_q       <= 1'b0;
    end else begin
      done_q   <= (accept && zero_size) || finish;
      s1_valid <= rd_en;
      if (accept) begin
        src_row      <= cmd_src;
        dst_row      <= cmd_dst;
        src_stride_q <= cmd_src_stride;
        dst_stride_q <= cmd_dst_stride;
        w_last       <= cmd_w - DIM_W'(1);
        h_last       <= cmd_h - DIM_W'(1);
        key_en_q     <= cmd_key_en;
        key_q        <= cmd_key;
        x_cnt        <= '0;
        y_cnt        <= '0;
        rd_pending   <= !zero_size;
      end else if (rd_en) begin
        s1_tag <= dst_row + ADDR_W'(x_cnt);
        if (last_col) begin
          x_cnt   <= '0;
          y_cnt   <= y_cnt + DIM_W'(1);
          src_row <= src_row + src_stride_q;
          dst_row <= dst_row + dst_stride_q;
          if (last_row) begin
            rd_pending <= 1'b0;
          end
        end else begin
          x_cnt <= x_cnt + DIM_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // NOTE: the FIFO storage is reset because its head drives wr_addr and
      // wr_data directly, which must read zero out of reset.
      for (int i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_addr[i] <= '0;
      end
      head_ptr <= 1'b0;
      tail_ptr <= 1'b0;
      occ      <= 2'd0;
    end else begin
      if (s1_valid) begin
        fifo_data[tail_ptr] <= rd_data;
        fifo_addr[tail_ptr] <= s1_tag;
        tail_ptr            <= ~tail_ptr;
      end
      if (pop) begin
        head_ptr <= ~head_ptr;
      end
      occ <= fill_next[1:0];
    end
  end

endmodule

// File: tb/tb_blit_rect_copy.sv
// Directed bench for blit_rect_copy: sprite memory model, write/read monitor and
// hand-computed expectations for copy, keying, backpressure, zero size, wrap, reset.
module tb_blit_rect_copy;
  localparam int ADDR_W = 16;
  localparam int PIX_W  = 8;
  localparam int DIM_W  = 8;

  logic              clock;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_src;
  logic [ADDR_W-1:0] cmd_dst;
  logic [DIM_W-1:0]  cmd_w;
  logic [DIM_W-1:0]  cmd_h;
  logic [ADDR_W-1:0] cmd_src_stride;
  logic [ADDR_W-1:0] cmd_dst_stride;
  logic              cmd_key_en;
  logic [PIX_W-1:0]  cmd_key;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [PIX_W-1:0]  rd_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [PIX_W-1:0]  wr_data;
  logic              wr_ready;
  logic              busy;
  logic              done;

  blit_rect_copy #(.ADDR_W(ADDR_W), .PIX_W(PIX_W), .DIM_W(DIM_W)) dut (
    .clock          (clock),
    .reset          (reset),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_src        (cmd_src),
    .cmd_dst        (cmd_dst),
    .cmd_w          (cmd_w),
    .cmd_h          (cmd_h),
    .cmd_src_stride (cmd_src_stride),
    .cmd_dst_stride (cmd_dst_stride),
    .cmd_key_en     (cmd_key_en),
    .cmd_key        (cmd_key),
    .rd_en          (rd_en),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .wr_ready       (wr_ready),
    .busy           (busy),
    .done           (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [PIX_W-1:0] mem [0:65535];

  initial rd_data = '0;
  always @(posedge clock) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

  // Monitor: samples on the falling edge, where handshakes are stable.
  logic [ADDR_W-1:0] rd_log [$];
  int                rd_cyc [$];
  logic [23:0]       wr_log [$];
  int                cyc = 0;
  int                rd_total = 0;
  int                wr_total = 0;
  int                max_outst = 0;
  int                stall_viol = 0;
  int                done_cnt = 0;
  int                done_cyc = 0;
  int                wr_cyc_last = 0;
  logic              prev_stall = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;
  logic [PIX_W-1:0]  prev_data = '0;

  always @(negedge clock) begin
    if (reset) begin
      prev_stall <= 1'b0;
    end else begin
      cyc <= cyc + 1;
      if (rd_total - wr_total > max_outst) max_outst <= rd_total - wr_total;
      if (prev_stall && (!wr_en || wr_addr !== prev_addr || wr_data !== prev_data))
        stall_viol <= stall_viol + 1;
      if (rd_en) begin
        rd_log.push_back(rd_addr);
        rd_cyc.push_back(cyc);
        rd_total <= rd_total + 1;
      end
      if (wr_en && wr_ready) begin
        wr_log.push_back({wr_addr, wr_data});
        wr_cyc_last <= cyc;
        wr_total    <= wr_total + 1;
      end
      if (done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
      prev_stall <= wr_en && !wr_ready;
      prev_addr  <= wr_addr;
      prev_data  <= wr_data;
    end
  end

  int passed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send(input logic [15:0] src, input logic [15:0] dst,
                      input logic [7:0] w, input logic [7:0] h,
                      input logic [15:0] ss, input logic [15:0] ds,
                      input logic ke, input logic [7:0] k, output logic rdy);
    @(posedge clock); #1;
    cmd_valid = 1'b1;
    cmd_src = src; cmd_dst = dst; cmd_w = w; cmd_h = h;
    cmd_src_stride = ss; cmd_dst_stride = ds; cmd_key_en = ke; cmd_key = k;
    @(negedge clock);
    rdy = cmd_ready;
    @(posedge clock); #1;
    // Scramble fields after acceptance; the engine must have latched them.
    cmd_valid = 1'b0;
    cmd_src = 16'hDEAD; cmd_dst = 16'hBEEF; cmd_w = 8'h33; cmd_h = 8'h44;
    cmd_src_stride = 16'h5555; cmd_dst_stride = 16'h6666; cmd_key_en = ~ke; cmd_key = 8'hEE;
  endtask

  task automatic wait_done(input int budget, input bit bp, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      wr_ready = bp ? (i % 4 == 3) : 1'b1;
      @(negedge clock); #1;
      if (done) begin
        got = 1'b1;
        break;
      end
      @(posedge clock); #1;
    end
    wr_ready = 1'b1;
  endtask

  initial begin
    int   r0, w0, d0;
    bit   got;
    logic rdy;

    reset = 1'b1;
    cmd_valid = 1'b0; cmd_src = '0; cmd_dst = '0; cmd_w = '0; cmd_h = '0;
    cmd_src_stride = '0; cmd_dst_stride = '0; cmd_key_en = 1'b0; cmd_key = '0;
    wr_ready = 1'b1;
    for (int i = 0; i < 65536; i++) mem[i] = '0;
    for (int i = 0; i < 8; i++) mem[16'h0100 + i] = 8'hA0 + 8'(i);
    mem[16'h0300] = 8'd5; mem[16'h0301] = 8'd0; mem[16'h0302] = 8'd7;
    for (int i = 0; i < 8; i++) mem[16'h0500 + i] = 8'h30 + 8'(i);
    mem[16'hFFFE] = 8'h11; mem[16'hFFFF] = 8'h22; mem[16'h0000] = 8'h33; mem[16'h0001] = 8'h44;
    for (int i = 0; i < 16; i++) mem[16'h0700 + i] = 8'h70 + 8'(i);
    mem[16'h0800] = 8'h91; mem[16'h0801] = 8'h92;

    // Reset state
    repeat (2) @(negedge clock);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_rd_en", 32'(rd_en), 32'd0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_addrs", {rd_addr, wr_addr}, 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Basic 4x2 copy
    r0 = rd_log.size(); w0 = wr_log.size(); d0 = done_cnt;
    send(16'h0100, 16'h2000, 8'd4, 8'd2, 16'd4, 16'd320, 1'b0, 8'h00, rdy);
    check("basic_accept_ready", 32'(rdy), 32'd1);
    wait_done(60, 1'b0, got);
    check("basic_done_seen", 32'(got), 32'd1);
    check("basic_rd_count", rd_log.size() - r0, 32'd8);
    for (int i = 0; i < 8; i++)
      check($sformatf("basic_rd_addr%0d", i), 32'(rd_log[r0 + i]), 32'h0100 + i);
    check("basic_rd_back_to_back", rd_cyc[r0 + 7] - rd_cyc[r0], 32'd7);
    check("basic_wr_count", wr_log.size() - w0, 32'd8);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("basic_wr_row0_%0d", i), 32'(wr_log[w0 + i]),
            {8'h00, 16'h2000 + 16'(i), 8'hA0 + 8'(i)});
      check($sformatf("basic_wr_row1_%0d", i), 32'(wr_log[w0 + 4 + i]),
            {8'h00, 16'h2140 + 16'(i), 8'hA4 + 8'(i)});
    end
    check("basic_done_after_last_wr", done_cyc - wr_cyc_last, 32'd1);
    check("basic_done_ready", 32'(cmd_ready), 32'd1);
    @(negedge clock); #1;
    check("basic_done_pulse_count", done_cnt - d0, 32'd1);

    // Transparency keying
    w0 = wr_log.size(); d0 = done_cnt;
    send(16'h0300, 16'h4000, 8'd3, 8'd1, 16'd3, 16'd3, 1'b1, 8'h00, rdy);
    wait_done(40, 1'b0, got);
    check("key_done_seen", 32'(got), 32'd1);
    check("key_wr_count", wr_log.size() - w0, 32'd2);
    check("key_wr0", 32'(wr_log[w0]), {8'h00, 16'h4000, 8'd5});
    check("key_wr1", 32'(wr_log[w0 + 1]), {8'h00, 16'h4002, 8'd7});

    // Backpressure: wr_ready high one cycle in four
    w0 = wr_log.size();
    send(16'h0500, 16'h5000, 8'd8, 8'd1, 16'd8, 16'd8, 1'b0, 8'h00, rdy);
    wait_done(200, 1'b1, got);
    check("bp_done_seen", 32'(got), 32'd1);
    check("bp_stall_stable", stall_viol, 32'd0);
    check("bp_outstanding_le3", 32'(max_outst <= 3), 32'd1);
    check("bp_wr_count", wr_log.size() - w0, 32'd8);
    for (int i = 0; i < 8; i++)
      check($sformatf("bp_wr%0d", i), 32'(wr_log[w0 + i]),
            {8'h00, 16'h5000 + 16'(i), 8'h30 + 8'(i)});

    // Zero size
    r0 = rd_log.size(); w0 = wr_log.size(); d0 = done_cnt;
    send(16'h0100, 16'h2000, 8'd0, 8'd5, 16'd4, 16'd4, 1'b0, 8'h00, rdy);
    wait_done(1, 1'b0, got);
    check("zero_done_next_cycle", 32'(got), 32'd1);
    check("zero_cmd_ready", 32'(cmd_ready), 32'd1);
    check("zero_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clock);
    #1;
    check("zero_no_rd", rd_log.size() - r0, 32'd0);
    check("zero_no_wr", wr_log.size() - w0, 32'd0);
    check("zero_one_done", done_cnt - d0, 32'd1);

    // Address wrap
    r0 = rd_log.size();
    send(16'hFFFE, 16'h3000, 8'd4, 8'd1, 16'd4, 16'd4, 1'b0, 8'h00, rdy);
    wait_done(40, 1'b0, got);
    check("wrap_done_seen", 32'(got), 32'd1);
    check("wrap_rd0", 32'(rd_log[r0]), 32'hFFFE);
    check("wrap_rd1", 32'(rd_log[r0 + 1]), 32'hFFFF);
    check("wrap_rd2", 32'(rd_log[r0 + 2]), 32'h0000);
    check("wrap_rd3", 32'(rd_log[r0 + 3]), 32'h0001);

    // Reset during the third write of a 4x4 blit
    w0 = wr_log.size(); d0 = done_cnt;
    send(16'h0700, 16'h6000, 8'd4, 8'd4, 16'd4, 16'd4, 1'b0, 8'h00, rdy);
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock); #1;
      if (wr_log.size() - w0 == 3) begin
        got = 1'b1;
        break;
      end
    end
    check("rstmid_reached_3rd_wr", 32'(got), 32'd1);
    check("rstmid_wr_en_before", 32'(wr_en), 32'd1);
    reset = 1'b1;
    #1;
    check("rstmid_rd_en", 32'(rd_en), 32'd0);
    check("rstmid_wr_en", 32'(wr_en), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rstmid_addrs", {rd_addr, wr_addr}, 32'd0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    r0 = rd_log.size(); w0 = wr_log.size();
    repeat (5) @(negedge clock);
    #1;
    check("rstmid_no_done", done_cnt - d0, 32'd0);
    check("rstmid_quiet_rd", rd_log.size() - r0, 32'd0);
    check("rstmid_quiet_wr", wr_log.size() - w0, 32'd0);
    send(16'h0800, 16'h7000, 8'd2, 8'd1, 16'd2, 16'd2, 1'b0, 8'h00, rdy);
    wait_done(40, 1'b0, got);
    check("fresh_done_seen", 32'(got), 32'd1);
    check("fresh_wr_count", wr_log.size() - w0, 32'd2);
    check("fresh_wr0", 32'(wr_log[w0]), {8'h00, 16'h7000, 8'h91});
    check("fresh_wr1", 32'(wr_log[w0 + 1]), {8'h00, 16'h7001, 8'h92});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
